// File: rtl/iir_coef_bank.sv
// Double-buffered coefficient bank for the biquad cascade: shadow/active copy gated by the compute window.
// Optional COEF_READBACK_EN adds a registered shadow read port (rd_en/rd_addr/rd_data).
module iir_coef_bank #(
    parameter int CASCADE_LEVEL = 10,
    parameter int CWIDTH        = 24,
    parameter int AWIDTH        = 6
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              block_en,
    input  logic                              din_vld,
    input  logic                              wr_en,
    input  logic [AWIDTH-1:0]                 wr_addr,
    input  logic [CWIDTH-1:0]                 wr_data,
    input  logic                              commit,
    output logic [CASCADE_LEVEL*CWIDTH*5-1:0] coefs,
    output logic                              commit_pending,
    output logic                              commit_done,
    output logic                              wr_err
`ifdef COEF_READBACK_EN
    ,
    input  logic                              rd_en,
    input  logic [AWIDTH-1:0]                 rd_addr,
    output logic [CWIDTH-1:0]                 rd_data
`endif
);

    // state   | meaning
    // IDLE    | no copy outstanding, shadow writable
    // PENDING | commit accepted, waiting for a non-busy cycle to copy
    typedef enum logic {IDLE, PENDING} state_t;

    localparam int NWORDS = CASCADE_LEVEL * 5;
    localparam int BW     = NWORDS * CWIDTH;
    localparam int CNT_W  = $clog2(CASCADE_LEVEL + 2);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CASCADE_LEVEL + 1);

    state_t              state;
    logic [CNT_W-1:0]    busy_cnt;
    logic                busy;
    logic [CWIDTH-1:0]   shadow [NWORDS];
    logic                wr_in_range;
    logic                wr_ok;
    logic [BW-1:0]       merged;

    assign busy        = din_vld | (busy_cnt != '0);
    assign wr_in_range = 32'(wr_addr) < NWORDS;
    assign wr_ok       = wr_en & wr_in_range & ~commit_pending;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_cnt <= '0;
        end else if (!block_en) begin
            busy_cnt <= '0;
        end else if (din_vld) begin
            busy_cnt <= CNT_LOAD;
        end else if (busy_cnt != '0) begin
            busy_cnt <= busy_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NWORDS; i++) shadow[i] <= '0;
        end else if (wr_ok) begin
            shadow[wr_addr] <= wr_data;
        end
    end

    // Same-cycle write is folded into the copy so a commit issued with block_en low sees it.
    always_comb begin
        merged = '0;
        for (int i = 0; i < NWORDS; i++) begin
            merged[i*CWIDTH +: CWIDTH] = (wr_ok && 32'(wr_addr) == i) ? wr_data : shadow[i];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            commit_pending <= 1'b0;
            commit_done    <= 1'b0;
            wr_err         <= 1'b0;
            coefs          <= '0;
        end else begin
            commit_done <= 1'b0;
            if (!block_en) begin
                state          <= IDLE;
                commit_pending <= 1'b0;
                wr_err         <= 1'b0;
                if (commit) begin
                    coefs       <= merged;
                    commit_done <= 1'b1;
                end
            end else begin
                wr_err <= wr_en & ~wr_ok;
                case (state)
                    IDLE: begin
                        if (commit) begin
                            state          <= PENDING;
                            commit_pending <= 1'b1;
                        end
                    end
                    PENDING: begin
                        if (!busy) begin
                            coefs          <= merged;
                            state          <= IDLE;
                            commit_pending <= 1'b0;
                            commit_done    <= 1'b1;
                        end
                    end
                    default: begin
                        state          <= IDLE;
                        commit_pending <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef COEF_READBACK_EN
    logic rd_in_range;
    assign rd_in_range = 32'(rd_addr) < NWORDS;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_in_range ? shadow[rd_addr] : '0;
        end
    end
`endif

endmodule

// File: tb/tb_iir_coef_bank.sv
// Self-checking bench for iir_coef_bank: directed scenarios plus random traffic against a cycle-level model.
module tb_iir_coef_bank;
    localparam int L  = 10;
    localparam int CW = 24;
    localparam int AW = 6;
    localparam int NW = L * 5;
    localparam int BW = NW * CW;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          block_en = 1'b0;
    logic          din_vld = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [CW-1:0] wr_data = '0;
    logic          commit = 1'b0;
    logic [BW-1:0] coefs;
    logic          commit_pending;
    logic          commit_done;
    logic          wr_err;
`ifdef COEF_READBACK_EN
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [CW-1:0] rd_data;
`endif

    iir_coef_bank #(.CASCADE_LEVEL(L), .CWIDTH(CW), .AWIDTH(AW)) dut (
        .clk(clk), .rstn(rstn), .block_en(block_en), .din_vld(din_vld),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit),
        .coefs(coefs), .commit_pending(commit_pending), .commit_done(commit_done),
        .wr_err(wr_err)
`ifdef COEF_READBACK_EN
        , .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: banks as word arrays, busy derived from the age of the last strobe.
    logic [CW-1:0] m_sh  [NW];
    logic [CW-1:0] m_act [NW];
    logic [CW-1:0] m_rd;
    bit            m_pend, m_done, m_err, have_last;
    int            cyc, last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] model_bus();
        logic [BW-1:0] v;
        for (int i = 0; i < NW; i++) v[i*CW +: CW] = m_act[i];
        return v;
    endfunction

    task automatic chk_bus(input string tag);
        logic [BW-1:0] exp;
        int w;
        exp = model_bus();
        w = 0;
        n_cmp++;
        assert (coefs === exp) else begin
            for (int i = NW - 1; i >= 0; i--) if (coefs[i*CW +: CW] !== exp[i*CW +: CW]) w = i;
            n_bad++;
            $error("FAIL %s word %0d observed=0x%0h expected=0x%0h", tag, w, coefs[w*CW +: CW], exp[w*CW +: CW]);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NW; i++) begin
            m_sh[i]  = '0;
            m_act[i] = '0;
        end
        m_rd = '0; m_pend = 0; m_done = 0; m_err = 0; have_last = 0; cyc = 0; last = 0;
    endtask

    task automatic check_all(input string tag);
        chk_bus({tag, "/coefs"});
        chk({tag, "/commit_pending"}, 32'(commit_pending), 32'(m_pend));
        chk({tag, "/commit_done"}, 32'(commit_done), 32'(m_done));
        chk({tag, "/wr_err"}, 32'(wr_err), 32'(m_err));
`ifdef COEF_READBACK_EN
        chk({tag, "/rd_data"}, 32'(rd_data), 32'(m_rd));
`endif
    endtask

    // One clock cycle: advance the model on the current inputs, clock, then compare.
    task automatic tick(input string tag);
        bit busy, wok;
        busy = din_vld || (have_last && (cyc - last) <= L + 1);
        wok  = wr_en && (int'(wr_addr) < NW) && !m_pend;
`ifdef COEF_READBACK_EN
        if (rd_en) m_rd = (int'(rd_addr) < NW) ? m_sh[rd_addr] : '0;
`endif
        m_err  = block_en && wr_en && !wok;
        m_done = 0;
        if (wok) m_sh[wr_addr] = wr_data;
        if (!block_en) begin
            if (commit) begin
                m_act  = m_sh;
                m_done = 1;
            end
            m_pend    = 0;
            have_last = 0;
        end else if (!m_pend) begin
            if (commit) m_pend = 1;
        end else if (!busy) begin
            m_act  = m_sh;
            m_pend = 0;
            m_done = 1;
        end
        if (block_en && din_vld) begin
            last      = cyc;
            have_last = 1;
        end
        cyc++;
        @(posedge clk);
        #1;
        check_all(tag);
        din_vld = 0; wr_en = 0; commit = 0;
`ifdef COEF_READBACK_EN
        rd_en = 0;
`endif
    endtask

    task automatic wr(input int a, input logic [CW-1:0] d);
        wr_en = 1; wr_addr = AW'(a); wr_data = d;
        tick("write");
    endtask

    logic [BW-1:0] prev_bus;
    int            changes;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rstn = 1; block_en = 1;
        tick("post_reset");

        // Idle commit latency
        wr(0, 24'h400000);
        wr(49, 24'h123456);
        commit = 1;
        tick("idle_commit_C");
        chk("idle_pending_C1", 32'(commit_pending), 32'd1);
        tick("idle_commit_C1");
        chk("idle_word0", 32'(coefs[23:0]), 32'h400000);
        chk("idle_word49", 32'(coefs[1199:1176]), 32'h123456);
        chk("idle_done_C2", 32'(commit_done), 32'd1);
        tick("idle_after");

        // Commit one cycle after a strobe: copy at the end of T+12
        wr(5, 24'h5A5A5A);
        din_vld = 1;
        tick("busy_T");
        commit = 1;
        tick("busy_T1");
        for (int k = 2; k <= 11; k++) tick("busy_wait");
        chk("busy_pending_T11", 32'(commit_pending), 32'd1);
        chk("busy_word5_old", 32'(coefs[5*CW +: CW]), 32'd0);
        tick("busy_T12");
        chk("busy_word5_new", 32'(coefs[5*CW +: CW]), 32'h5A5A5A);
        tick("busy_after");

        // Rejected writes
        wr(50, 24'hDEAD01);
        chk("err_addr50", 32'(wr_err), 32'd1);
        wr(63, 24'hDEAD02);
        din_vld = 1;
        tick("pend_err_T");
        commit = 1;
        tick("pend_err_T1");
        wr(3, 24'h333333);
        chk("err_while_pending", 32'(wr_err), 32'd1);
        for (int k = 0; k < 12; k++) tick("pend_err_wait");
        chk("word3_not_copied", 32'(coefs[3*CW +: CW]), 32'd0);

        // block_en drop cancels a pending commit
        wr(7, 24'h777777);
        din_vld = 1;
        tick("cancel_T");
        commit = 1;
        tick("cancel_T1");
        for (int k = 2; k <= 4; k++) tick("cancel_wait");
        block_en = 0;
        tick("cancel_T5");
        chk("cancel_pending", 32'(commit_pending), 32'd0);
        for (int k = 0; k < 14; k++) tick("cancel_off");
        chk("cancel_word7_old", 32'(coefs[7*CW +: CW]), 32'd0);
        block_en = 1;
        for (int k = 0; k < 3; k++) tick("cancel_on");

        // Strobe every 13 cycles leaves exactly one free cycle per period
        wr(9, 24'h999999);
        changes = 0;
        for (int j = 0; j < 52; j++) begin
            din_vld  = (j % 13 == 0);
            commit   = (j == 1);
            prev_bus = coefs;
            tick("periodic");
            if (coefs !== prev_bus) begin
                changes++;
                chk("periodic_copy_slot", 32'(j % 13), 32'd12);
            end
        end
        chk("periodic_one_copy", 32'(changes), 32'd1);
        chk("periodic_word9", 32'(coefs[9*CW +: CW]), 32'h999999);

        // block_en low: commit copies at once, including a same-cycle write
        block_en = 0;
        tick("off_idle");
        wr_en = 1; wr_addr = 6'd11; wr_data = 24'hB0B0B0; commit = 1;
        tick("off_commit");
        chk("off_word11", 32'(coefs[11*CW +: CW]), 32'hB0B0B0);
        chk("off_done", 32'(commit_done), 32'd1);
        block_en = 1;
        tick("off_back_on");

        // Random traffic
        for (int j = 0; j < 400; j++) begin
            block_en = ($urandom_range(0, 24) != 0);
            din_vld  = ($urandom_range(0, 9) == 0);
            wr_en    = ($urandom_range(0, 2) == 0);
            wr_addr  = AW'($urandom_range(0, 63));
            wr_data  = CW'($urandom);
            commit   = ($urandom_range(0, 11) == 0);
`ifdef COEF_READBACK_EN
            rd_en    = ($urandom_range(0, 3) == 0);
            rd_addr  = AW'($urandom_range(0, 63));
`endif
            tick("random");
        end
        block_en = 1;
        for (int k = 0; k < 14; k++) tick("random_drain");

        // Async reset in the middle of a pending commit
        wr(1, 24'h111111);
        din_vld = 1;
        tick("arst_T");
        commit = 1;
        tick("arst_T1");
        tick("arst_T2");
        #2 rstn = 0;
        #1;
        model_reset();
        check_all("arst_async");
        @(posedge clk);
        #1;
        check_all("arst_held");
        rstn = 1;
        tick("arst_release");

`ifdef COEF_READBACK_EN
        wr(7, 24'hABCDEF);
        rd_en = 1; rd_addr = 6'd7;
        tick("rd_addr7");
        chk("rd_7", 32'(rd_data), 32'hABCDEF);
        rd_en = 1; rd_addr = 6'd60;
        tick("rd_addr60");
        chk("rd_60", 32'(rd_data), 32'd0);
        rd_en = 1; rd_addr = 6'd7; wr_en = 1; wr_addr = 6'd7; wr_data = 24'h0F0F0F;
        tick("rd_wr_same");
        chk("rd_old_value", 32'(rd_data), 32'hABCDEF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
